// File: rtl/buffer_ex_mem.sv
// EX/MEM pipeline register: captures EX results and control for the MEM stage,
// with stall/flush, LW/SW word-alignment checking and debug counters.
module buffer_ex_mem #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valido_EX,
    input  logic             reg_escribir_EX,
    input  logic             mem_a_reg_EX,
    input  logic             mem_escribir_EX,
    input  logic             mem_leer_EX,
    input  logic [ANCHO-1:0] resultado_alu_EX,
    input  logic [ANCHO-1:0] dr2_forward_EX,
    input  logic [4:0]       registro_destino_EX,
    input  logic             stall_MEM,
    input  logic             flush_MEM,
    input  logic             limpiar_excepcion,
    output logic             reg_escribir_MEM,
    output logic             mem_a_reg_MEM,
    output logic             mem_escribir_MEM,
    output logic             mem_leer_MEM,
    output logic [ANCHO-1:0] resultado_alu_MEM,
    output logic [ANCHO-1:0] dr2_forward_MEM,
    output logic [4:0]       registro_destino_MEM,
    output logic             valido_MEM,
    output logic             excepcion_MEM,
    output logic             excepcion_pendiente,
    output logic [ANCHO-1:0] direccion_fallo,
    output logic [31:0]      contador_instr,
    output logic [31:0]      contador_burbujas
);

    function automatic logic es_desalineado(input logic leer, input logic escribir,
                                            input logic [1:0] dir_lsb);
        return (leer | escribir) & (dir_lsb != 2'b00);
    endfunction

    logic carga_s;
    logic burbuja_s;
    logic fallo_s;
    logic pendiente_sig_s;
    logic actualizar_dir_s;

    // Decide this edge's action and the next sticky-fault state.
    always_comb begin
        carga_s          = 1'b0;
        burbuja_s        = 1'b0;
        fallo_s          = 1'b0;
        pendiente_sig_s  = excepcion_pendiente;
        actualizar_dir_s = 1'b0;
        if (flush_MEM) begin
            burbuja_s = 1'b1;
        end else if (stall_MEM) begin
            burbuja_s = 1'b0;
        end else if (valido_EX) begin
            carga_s = 1'b1;
            fallo_s = es_desalineado(mem_leer_EX, mem_escribir_EX, resultado_alu_EX[1:0]);
        end else begin
            burbuja_s = 1'b1;
        end
        // A fresh fault beats a simultaneous clear and re-arms the address capture.
        if (fallo_s) begin
            pendiente_sig_s  = 1'b1;
            actualizar_dir_s = ~excepcion_pendiente | limpiar_excepcion;
        end else if (limpiar_excepcion) begin
            pendiente_sig_s = 1'b0;
        end else begin
            pendiente_sig_s = excepcion_pendiente;
        end
    end

    // Pipeline register, fault tracking and debug counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_escribir_MEM     <= 1'b0;
            mem_a_reg_MEM        <= 1'b0;
            mem_escribir_MEM     <= 1'b0;
            mem_leer_MEM         <= 1'b0;
            resultado_alu_MEM    <= {ANCHO{1'b0}};
            dr2_forward_MEM      <= {ANCHO{1'b0}};
            registro_destino_MEM <= 5'd0;
            valido_MEM           <= 1'b0;
            excepcion_MEM        <= 1'b0;
            excepcion_pendiente  <= 1'b0;
            direccion_fallo      <= {ANCHO{1'b0}};
            contador_instr       <= 32'd0;
            contador_burbujas    <= 32'd0;
        end else begin
            if (burbuja_s) begin
                reg_escribir_MEM     <= 1'b0;
                mem_a_reg_MEM        <= 1'b0;
                mem_escribir_MEM     <= 1'b0;
                mem_leer_MEM         <= 1'b0;
                resultado_alu_MEM    <= {ANCHO{1'b0}};
                dr2_forward_MEM      <= {ANCHO{1'b0}};
                registro_destino_MEM <= 5'd0;
                valido_MEM           <= 1'b0;
                excepcion_MEM        <= 1'b0;
                contador_burbujas    <= contador_burbujas + 32'd1;
            end else if (carga_s) begin
                // A misaligned access travels on as a valid instruction with its side effects masked.
                reg_escribir_MEM     <= reg_escribir_EX & ~fallo_s;
                mem_a_reg_MEM        <= mem_a_reg_EX;
                mem_escribir_MEM     <= mem_escribir_EX & ~fallo_s;
                mem_leer_MEM         <= mem_leer_EX & ~fallo_s;
                resultado_alu_MEM    <= resultado_alu_EX;
                dr2_forward_MEM      <= dr2_forward_EX;
                registro_destino_MEM <= registro_destino_EX;
                valido_MEM           <= 1'b1;
                excepcion_MEM        <= fallo_s;
                contador_instr       <= contador_instr + 32'd1;
            end else begin
                excepcion_MEM <= 1'b0;
            end
            excepcion_pendiente <= pendiente_sig_s;
            if (actualizar_dir_s) begin
                direccion_fallo <= resultado_alu_EX;
            end else begin
                direccion_fallo <= direccion_fallo;
            end
        end
    end

endmodule

// File: tb/tb_buffer_ex_mem.sv
// Self-checking bench for buffer_ex_mem: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX/MEM register.
module tb_buffer_ex_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valido_EX = 1'b0, reg_escribir_EX = 1'b0, mem_a_reg_EX = 1'b0;
    logic        mem_escribir_EX = 1'b0, mem_leer_EX = 1'b0;
    logic [31:0] resultado_alu_EX = 32'd0, dr2_forward_EX = 32'd0;
    logic [4:0]  registro_destino_EX = 5'd0;
    logic        stall_MEM = 1'b0, flush_MEM = 1'b0, limpiar_excepcion = 1'b0;
    logic        reg_escribir_MEM, mem_a_reg_MEM, mem_escribir_MEM, mem_leer_MEM;
    logic [31:0] resultado_alu_MEM, dr2_forward_MEM, direccion_fallo;
    logic [4:0]  registro_destino_MEM;
    logic        valido_MEM, excepcion_MEM, excepcion_pendiente;
    logic [31:0] contador_instr, contador_burbujas;

    buffer_ex_mem #(.ANCHO(32)) dut (
        .clk(clk), .rst(rst),
        .valido_EX(valido_EX), .reg_escribir_EX(reg_escribir_EX),
        .mem_a_reg_EX(mem_a_reg_EX), .mem_escribir_EX(mem_escribir_EX),
        .mem_leer_EX(mem_leer_EX), .resultado_alu_EX(resultado_alu_EX),
        .dr2_forward_EX(dr2_forward_EX), .registro_destino_EX(registro_destino_EX),
        .stall_MEM(stall_MEM), .flush_MEM(flush_MEM),
        .limpiar_excepcion(limpiar_excepcion),
        .reg_escribir_MEM(reg_escribir_MEM), .mem_a_reg_MEM(mem_a_reg_MEM),
        .mem_escribir_MEM(mem_escribir_MEM), .mem_leer_MEM(mem_leer_MEM),
        .resultado_alu_MEM(resultado_alu_MEM), .dr2_forward_MEM(dr2_forward_MEM),
        .registro_destino_MEM(registro_destino_MEM), .valido_MEM(valido_MEM),
        .excepcion_MEM(excepcion_MEM), .excepcion_pendiente(excepcion_pendiente),
        .direccion_fallo(direccion_fallo), .contador_instr(contador_instr),
        .contador_burbujas(contador_burbujas)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what MEM should be holding.
    typedef struct packed {
        logic        rw, m2r, mw, mr;
        logic [31:0] alu, dr2;
        logic [4:0]  rd;
        logic        vld, exc, pend;
        logic [31:0] dir, ninstr, nburb;
    } mem_t;
    mem_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '0;
    endtask

    // Apply the pipeline register's rules to the inputs present at this edge.
    task automatic model_edge();
        logic misal, fault;
        fault = 1'b0;
        if (flush_MEM || (!stall_MEM && !valido_EX)) begin
            m.rw = 0; m.m2r = 0; m.mw = 0; m.mr = 0;
            m.alu = 0; m.dr2 = 0; m.rd = 0; m.vld = 0; m.exc = 0;
            m.nburb = m.nburb + 1;
        end else if (stall_MEM) begin
            m.exc = 0;
        end else begin
            misal = (mem_leer_EX || mem_escribir_EX) && (resultado_alu_EX % 4 != 0);
            m.rw  = misal ? 1'b0 : reg_escribir_EX;
            m.mw  = misal ? 1'b0 : mem_escribir_EX;
            m.mr  = misal ? 1'b0 : mem_leer_EX;
            m.m2r = mem_a_reg_EX;
            m.alu = resultado_alu_EX; m.dr2 = dr2_forward_EX; m.rd = registro_destino_EX;
            m.vld = 1; m.exc = misal;
            m.ninstr = m.ninstr + 1;
            fault = misal;
        end
        if (fault && (!m.pend || limpiar_excepcion)) m.dir = resultado_alu_EX;
        if (fault) m.pend = 1;
        else if (limpiar_excepcion) m.pend = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".reg_escribir"}, {31'd0, reg_escribir_MEM}, {31'd0, m.rw});
        chk({tag, ".mem_a_reg"},    {31'd0, mem_a_reg_MEM},    {31'd0, m.m2r});
        chk({tag, ".mem_escribir"}, {31'd0, mem_escribir_MEM}, {31'd0, m.mw});
        chk({tag, ".mem_leer"},     {31'd0, mem_leer_MEM},     {31'd0, m.mr});
        chk({tag, ".alu"},          resultado_alu_MEM,         m.alu);
        chk({tag, ".dr2"},          dr2_forward_MEM,           m.dr2);
        chk({tag, ".rd"},           {27'd0, registro_destino_MEM}, {27'd0, m.rd});
        chk({tag, ".valido"},       {31'd0, valido_MEM},       {31'd0, m.vld});
        chk({tag, ".excepcion"},    {31'd0, excepcion_MEM},    {31'd0, m.exc});
        chk({tag, ".pendiente"},    {31'd0, excepcion_pendiente}, {31'd0, m.pend});
        chk({tag, ".dir_fallo"},    direccion_fallo,           m.dir);
        chk({tag, ".n_instr"},      contador_instr,            m.ninstr);
        chk({tag, ".n_burb"},       contador_burbujas,         m.nburb);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic mw,
                          input logic mr, input logic [31:0] alu, input logic [31:0] dr2,
                          input logic [4:0] rd);
        valido_EX = v; reg_escribir_EX = rw; mem_a_reg_EX = m2r; mem_escribir_EX = mw;
        mem_leer_EX = mr; resultado_alu_EX = alu; dr2_forward_EX = dr2; registro_destino_EX = rd;
    endtask

    initial begin
        model_reset();
        // Power-on reset
        repeat (2) @(posedge clk);
        #1 check_all("por");
        @(negedge clk) rst = 1'b0;

        // LW 0x10 -> r8
        set_ex(1, 1, 1, 0, 1, 32'h10, 32'h0, 5'd8);
        tick("lw");
        chk("lw.mem_leer_lit", {31'd0, mem_leer_MEM}, 32'd1);
        chk("lw.alu_lit", resultado_alu_MEM, 32'h10);
        chk("lw.rd_lit", {27'd0, registro_destino_MEM}, 32'd8);
        chk("lw.ninstr_lit", contador_instr, 32'd1);

        // Four more aligned instructions, then reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 1, 0, 0, 0, 32'h100 + i * 4, 32'h0, 5'd3);
            tick("alu");
        end
        chk("pre_rst.ninstr", contador_instr, 32'd5);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        rst = 1'b0;
        set_ex(1, 1, 0, 0, 0, 32'h40, 32'h0, 5'd4);
        tick("post_rst");
        chk("post_rst.ninstr_lit", contador_instr, 32'd1);

        // Stall for 3 cycles while EX changes, then stall + flush
        stall_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 0, 0, 1, 0, 32'h200 + i * 8, 32'h1234 + i, 5'd9 + i);
            tick("stall");
        end
        chk("stall.alu_lit", resultado_alu_MEM, 32'h40);
        flush_MEM = 1'b1;
        tick("flush");
        chk("flush.burb_lit", contador_burbujas, 32'd1);
        stall_MEM = 1'b0; flush_MEM = 1'b0;

        // Misaligned SW at 0x6, then misaligned LW at 0xB
        set_ex(1, 0, 0, 1, 0, 32'h6, 32'hDEADBEEF, 5'd0);
        tick("sw_mis");
        chk("sw_mis.exc_lit", {31'd0, excepcion_MEM}, 32'd1);
        chk("sw_mis.dir_lit", direccion_fallo, 32'h6);
        set_ex(1, 1, 1, 0, 1, 32'hB, 32'h0, 5'd7);
        tick("lw_mis2");
        chk("lw_mis2.dir_lit", direccion_fallo, 32'h6);
        set_ex(1, 1, 0, 0, 0, 32'h8, 32'h0, 5'd2);
        tick("after_mis");

        // Clear racing a new fault, then a plain clear
        limpiar_excepcion = 1'b1;
        set_ex(1, 1, 1, 0, 1, 32'h21, 32'h0, 5'd5);
        tick("clr_race");
        chk("clr_race.dir_lit", direccion_fallo, 32'h21);
        chk("clr_race.pend_lit", {31'd0, excepcion_pendiente}, 32'd1);
        set_ex(1, 1, 1, 0, 1, 32'h24, 32'h0, 5'd5);
        tick("clr");
        chk("clr.pend_lit", {31'd0, excepcion_pendiente}, 32'd0);
        limpiar_excepcion = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            stall_MEM         = ($urandom_range(0, 4) == 0);
            flush_MEM         = ($urandom_range(0, 7) == 0);
            limpiar_excepcion = ($urandom_range(0, 9) == 0);
            set_ex($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom, $urandom, 5'($urandom));
            tick("rand");
        end
        stall_MEM = 1'b0; flush_MEM = 1'b0; limpiar_excepcion = 1'b0;

        // Bubble counter wrap
        @(negedge clk);
        force dut.contador_burbujas = 32'hFFFFFFFF;
        #1 release dut.contador_burbujas;
        m.nburb = 32'hFFFFFFFF;
        set_ex(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick("wrap");
        chk("wrap.burb_lit", contador_burbujas, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
